// File: rtl/lfsr_prng_pkg.sv
// lfsr_prng shared constants and default tap table.
// Tap masks use bit i = state[i] for a left-shifting Fibonacci LFSR.
package lfsr_prng_pkg;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Maximal-length tap masks, one per supported width.
    function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
        logic [31:0] t;
        t = 32'h0;
        case (width)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_prng_feedback.sv
// lfsr_prng feedback bit: XOR of the tapped state bits.
// Purely combinational.
module lfsr_prng_feedback #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic             fb
);

    assign fb = ^(state & taps);

endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng: free-running Fibonacci LFSR, state exposed as random_out.
// Optional macro LFSR_PRNG_LOCKUP_RECOVERY_EN reloads the seed from state 0.
module lfsr_prng
    import lfsr_prng_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] random_out
);

    localparam logic [31:0] TAPS_FULL =
        (TAPS != 32'h0) ? TAPS : lfsr_default_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS_EFF = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_RAW = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED_RAW == '0) ? SEED_ONE : SEED_RAW;

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "lfsr_prng: WIDTH %0d outside 3..32", WIDTH);
    end

    if (!TAPS_EFF[WIDTH-1]) begin : g_bad_taps
        $fatal(1, "lfsr_prng: tap mask must include bit WIDTH-1");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic             fb;

    lfsr_prng_feedback #(
        .WIDTH (WIDTH)
    ) u_feedback (
        .state (state),
        .taps  (TAPS_EFF),
        .fb    (fb)
    );

    // Shift left with feedback into bit 0; optionally escape lock-up.
    always_comb begin
        state_next = {state[WIDTH-2:0], fb};
`ifdef LFSR_PRNG_LOCKUP_RECOVERY_EN
        if (state == '0) state_next = SEED_EFF;
`endif
    end

    // State register, forced to the seed while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SEED_EFF;
        else        state <= state_next;
    end

    assign random_out = state;

endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed checks of reset, sequence, period, seeds, lock-up.
// Honors LFSR_PRNG_LOCKUP_RECOVERY_EN to pick lock-up expectations.
module tb_lfsr_prng;

    logic       clk;
    logic       reset;
    logic [7:0] rnd;
    logic [7:0] rnd_s0;
    logic [7:0] rnd_a5;

    int checks = 0;
    int errors = 0;

    lfsr_prng #(.WIDTH(8), .TAPS(32'h0), .SEED(32'h1)) dut (
        .clk        (clk),
        .reset      (reset),
        .random_out (rnd)
    );

    lfsr_prng #(.WIDTH(8), .TAPS(32'h0), .SEED(32'h0)) dut_s0 (
        .clk        (clk),
        .reset      (reset),
        .random_out (rnd_s0)
    );

    lfsr_prng #(.WIDTH(8), .TAPS(32'h0), .SEED(32'hA5)) dut_a5 (
        .clk        (clk),
        .reset      (reset),
        .random_out (rnd_a5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_exp [9] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                                8'h47, 8'h8E, 8'h1C, 8'h38};
    bit         seen [256];
    int         zeros;
    int         dups;
    int         distinct;

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_async", {24'h0, rnd}, 32'h01);
        check("reset_seed0", {24'h0, rnd_s0}, 32'h01);
        check("reset_seedA5", {24'h0, rnd_a5}, 32'hA5);
        #10;
        check("reset_hold", {24'h0, rnd}, 32'h01);

        @(negedge clk);
        reset = 1'b1;

        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        zeros = 0;
        dups = 0;
        distinct = 1;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i <= 9)
                check($sformatf("seq_%0d", i), {24'h0, rnd},
                      {24'h0, seq_exp[i-1]});
            if (i == 1)
                check("seedA5_step", {24'h0, rnd_a5}, 32'h4A);
            if (i < 255) begin
                if (rnd == 8'h00) zeros++;
                else if (seen[rnd]) dups++;
                else begin
                    seen[rnd] = 1'b1;
                    distinct++;
                end
            end
        end
        check("period_wrap", {24'h0, rnd}, 32'h01);
        check("period_zeros", zeros, 0);
        check("period_dups", dups, 0);
        check("period_distinct", distinct, 255);

        for (int i = 0; i < 20; i++) step();
        #2 reset = 1'b0;
        #1;
        check("mid_reset", {24'h0, rnd}, 32'h01);
        step();
        check("mid_hold", {24'h0, rnd}, 32'h01);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("mid_restart", {24'h0, rnd}, 32'h02);
        step();
        check("mid_restart2", {24'h0, rnd}, 32'h04);

        @(negedge clk);
        force dut.state = 8'h00;
        #1 release dut.state;
        #1;
        check("lock_forced", {24'h0, rnd}, 32'h00);
`ifdef LFSR_PRNG_LOCKUP_RECOVERY_EN
        step();
        check("lock_recover", {24'h0, rnd}, 32'h01);
        step();
        check("lock_resume", {24'h0, rnd}, 32'h02);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("lock_stuck_%0d", i), {24'h0, rnd}, 32'h00);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
